ex_operand_stage: RTL and testbench
===================================

# ex_operand_stage

ID/EX pipeline register plus operand-select logic for the 16-bit pipelined CPU. It captures decoded instructions, drives the operand and function-code inputs of the execute-stage ALU, and resolves register read-after-write hazards. Hazards are resolved either by forwarding from EX/MEM and MEM/WB or by stall requests. The stage honours a downstream stall (memory or DMA bus hold) and a branch flush.

## Interface
- W, 16, datapath width
- OPW, 6, ALU function-code width
- RW, 2, register-index width
- clk  in  1  clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- id_valid  in  1  decode presents an instruction
- id_op  in  OPW  ALU function code
- id_rs, id_rt  in  RW  source register indices
- id_use_rs, id_use_rt  in  1  instruction reads rs / rt
- id_rs_val, id_rt_val  in  W  register-file read data
- id_imm  in  8  raw immediate; the ALU performs sign handling
- id_use_imm  in  1  B operand := {8'b0, id_imm}
- id_pc  in  W  instruction PC
- id_use_pc  in  1  A operand := PC (BPC/JPC)
- id_wb, id_rd  in  1, RW  writes register rd
- stall  in  1  downstream hold
- flush  in  1  squash instruction in this stage
- exmem_wb, exmem_rd, exmem_val  in  1, RW, W  EX/MEM forward source
- memwb_wb, memwb_rd, memwb_val  in  1, RW, W  MEM/WB forward source
- id_ready  out  1  stage accepts id_* this cycle
- ex_valid  out  1  alu_* hold a live instruction
- alu_a, alu_b  out  W  ALU operands
- alu_op  out  OPW  ALU function code
- ex_wb, ex_rd  out  1, RW  destination, passed downstream

## Operation
- Registered fields: valid, op, rs, rt, use flags, rs_val, rt_val, imm, pc, wb, rd.
- alu_a = use_pc ? pc : fwd(rs, rs_val).
- alu_b = use_imm ? {8'b0, imm} : fwd(rt, rt_val).
- fwd(r, v) selects in priority order:
  - exmem_val if exmem_wb && exmem_rd==r
  - else memwb_val if memwb_wb && memwb_rd==r
  - else v
- Register-index 0 is a real register and is forwarded like any other.
- Hazard (hz, combinational, only when id_valid and the field's use flag is set):
  - With forwarding: ex_valid && ex_wb && alu_op==`FUNC_LWD && ex_rd matches id rs or rt (load-use).
  - Without forwarding: id rs or rt matches any of (ex_valid&&ex_wb, ex_rd), (exmem_wb, exmem_rd) or (memwb_wb, memwb_rd).
- id_ready = !stall && !hz.
- Per-edge update, highest priority first:
  - flush: valid←0.
  - stall: hold all fields. If memwb_wb matches a held rs or rt, overwrite rs_val / rt_val with memwb_val so the retiring value is not lost.
  - hz: valid←0 (bubble); other fields don't-care.
  - Otherwise: load all id_* fields, valid←id_valid.
- While ex_valid=0: ex_wb is forced to 0 and alu_op is driven as stored.

## Timing
- Reset values: ex_valid=0, ex_wb=0, ex_rd=0, alu_op=0, stored values 0, so alu_a=alu_b=0 when no forward source matches.
- Latency is 1 cycle from id_* capture to alu_* valid.
- Forwarding muxes are combinational in the EX cycle.
- id_ready is combinational. Decode must hold id_* unchanged while id_ready=0.
- A load-use hazard inserts exactly 1 bubble with forwarding. Without forwarding, at most 3 bubbles.
- flush and stall in the same cycle: flush wins, stage empties.
- Reset asserted mid-stall clears valid immediately (asynchronous).

## Configuration
- FORWARDING_EN defined: fwd muxes active; hz covers load-use only.
- FORWARDING_EN undefined: fwd(r, v)=v; hz uses the full three-source comparison.

## Test plan
- Reset, then ADD with rs_val=0x0003, rt_val=0x0004 → next cycle ex_valid=1, alu_a=0x0003, alu_b=0x0004.
- Back-to-back dependence (EX/MEM writes r1=0x1234, next instruction reads r1 with stale rs_val=0) → FORWARDING_EN: alu_a=0x1234, no bubble. Undefined: id_ready=0 until the writer leaves MEM/WB, then alu_a equals the updated register value.
- LWD to r2 followed by an instruction reading r2 → exactly one cycle with ex_valid=0, then alu_b=memwb_val.
- stall held 3 cycles while memwb writes r3=0xBEEF matching the held rs → after release alu_a=0xBEEF, and id_* was not consumed during the stall.
- flush together with stall → next cycle ex_valid=0, ex_wb=0.
- BPC with id_use_pc=1, pc=0x0010, imm=0xFE → alu_a=0x0010, alu_b=0x00FE, alu_op=`FUNC_BPC`.

Source files
------------

// File: rtl/ex_operand_stage.sv
// ex_operand_stage: ID/EX pipeline register with ALU operand select and RAW hazard handling; `define FORWARDING_EN enables EX/MEM and MEM/WB bypass
`ifndef FUNC_LWD
`define FUNC_LWD 6'h20
`endif
`ifndef FUNC_BPC
`define FUNC_BPC 6'h30
`endif
module ex_operand_stage #(
  parameter int W   = 16,
  parameter int OPW = 6,
  parameter int RW  = 2
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           id_valid,
  input  logic [OPW-1:0] id_op,
  input  logic [RW-1:0]  id_rs,
  input  logic [RW-1:0]  id_rt,
  input  logic           id_use_rs,
  input  logic           id_use_rt,
  input  logic [W-1:0]   id_rs_val,
  input  logic [W-1:0]   id_rt_val,
  input  logic [7:0]     id_imm,
  input  logic           id_use_imm,
  input  logic [W-1:0]   id_pc,
  input  logic           id_use_pc,
  input  logic           id_wb,
  input  logic [RW-1:0]  id_rd,
  input  logic           stall,
  input  logic           flush,
  input  logic           exmem_wb,
  input  logic [RW-1:0]  exmem_rd,
  input  logic [W-1:0]   exmem_val,
  input  logic           memwb_wb,
  input  logic [RW-1:0]  memwb_rd,
  input  logic [W-1:0]   memwb_val,
  output logic           id_ready,
  output logic           ex_valid,
  output logic [W-1:0]   alu_a,
  output logic [W-1:0]   alu_b,
  output logic [OPW-1:0] alu_op,
  output logic           ex_wb,
  output logic [RW-1:0]  ex_rd
);
  logic           v, urs, urt, uimm, upc, wb, hz;
  logic [OPW-1:0] op;
  logic [RW-1:0]  rs, rt, rd;
  logic [W-1:0]   rsv, rtv, pc, fa, fb;
  logic [7:0]     imm;
`ifdef FORWARDING_EN
  function automatic logic [W-1:0] fwd(input logic [RW-1:0] r, input logic [W-1:0] val);
    return (exmem_wb && exmem_rd == r) ? exmem_val : (memwb_wb && memwb_rd == r) ? memwb_val : val;
  endfunction
  function automatic logic pend(input logic [RW-1:0] r);
    return v && wb && op == OPW'(`FUNC_LWD) && rd == r;
  endfunction
  assign fa = fwd(rs, rsv);
  assign fb = fwd(rt, rtv);
`else
  function automatic logic pend(input logic [RW-1:0] r);
    return (v && wb && rd == r) || (exmem_wb && exmem_rd == r) || (memwb_wb && memwb_rd == r);
  endfunction
  logic unused_exmem_val;
  assign unused_exmem_val = ^exmem_val;
  assign fa = rsv;
  assign fb = rtv;
`endif
  assign hz       = id_valid && ((id_use_rs && pend(id_rs)) || (id_use_rt && pend(id_rt)));
  assign id_ready = !stall && !hz;
  assign ex_valid = v;
  assign ex_wb    = v && wb;
  assign ex_rd    = rd;
  assign alu_op   = op;
  assign alu_a    = upc ? pc : fa;
  assign alu_b    = uimm ? {{(W-8){1'b0}}, imm} : fb;
  // flush empties, stall holds while capturing retiring writes, hazard inserts a bubble, otherwise capture decode
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      v    <= 1'b0;
      op   <= '0;
      rs   <= '0;
      rt   <= '0;
      urs  <= 1'b0;
      urt  <= 1'b0;
      rsv  <= '0;
      rtv  <= '0;
      imm  <= '0;
      uimm <= 1'b0;
      pc   <= '0;
      upc  <= 1'b0;
      wb   <= 1'b0;
      rd   <= '0;
    end else if (flush) v <= 1'b0;
    else if (stall) begin
      if (memwb_wb && memwb_rd == rs) rsv <= memwb_val;
      if (memwb_wb && memwb_rd == rt) rtv <= memwb_val;
    end else begin
      v    <= id_valid && !hz;
      op   <= id_op;
      rs   <= id_rs;
      rt   <= id_rt;
      urs  <= id_use_rs;
      urt  <= id_use_rt;
      rsv  <= id_rs_val;
      rtv  <= id_rt_val;
      imm  <= id_imm;
      uimm <= id_use_imm;
      pc   <= id_pc;
      upc  <= id_use_pc;
      wb   <= id_wb;
      rd   <= id_rd;
    end
endmodule

// File: tb/tb_ex_operand_stage.sv
// tb_ex_operand_stage: directed scenarios plus random stimulus checked every cycle against an instruction-level model of the stage
`ifndef FUNC_LWD
`define FUNC_LWD 6'h20
`endif
`ifndef FUNC_BPC
`define FUNC_BPC 6'h30
`endif
module tb_ex_operand_stage;
  localparam logic [5:0] LWD = `FUNC_LWD;
  localparam logic [5:0] BPC = `FUNC_BPC;
  localparam logic [5:0] ADD = 6'h01;
`ifdef FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  logic clk = 1'b0, reset_n = 1'b0;
  logic id_valid, id_use_rs, id_use_rt, id_use_imm, id_use_pc, id_wb, stall, flush, exmem_wb, memwb_wb;
  logic [5:0] id_op;
  logic [1:0] id_rs, id_rt, id_rd, exmem_rd, memwb_rd;
  logic [15:0] id_rs_val, id_rt_val, id_pc, exmem_val, memwb_val;
  logic [7:0] id_imm;
  logic id_ready, ex_valid, ex_wb;
  logic [15:0] alu_a, alu_b;
  logic [5:0] alu_op;
  logic [1:0] ex_rd;
  int checks = 0, failures = 0;
  typedef struct packed {
    logic valid, use_rs, use_rt, use_imm, use_pc, wb;
    logic [5:0] op;
    logic [1:0] rs, rt, rd;
    logic [15:0] rs_val, rt_val, pc;
    logic [7:0] imm;
  } instr_t;
  instr_t m;
  logic ready_q;
  ex_operand_stage dut (
    .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_op(id_op), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rs_val(id_rs_val), .id_rt_val(id_rt_val),
    .id_imm(id_imm), .id_use_imm(id_use_imm), .id_pc(id_pc), .id_use_pc(id_use_pc), .id_wb(id_wb),
    .id_rd(id_rd), .stall(stall), .flush(flush), .exmem_wb(exmem_wb), .exmem_rd(exmem_rd),
    .exmem_val(exmem_val), .memwb_wb(memwb_wb), .memwb_rd(memwb_rd), .memwb_val(memwb_val),
    .id_ready(id_ready), .ex_valid(ex_valid), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .ex_wb(ex_wb), .ex_rd(ex_rd)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask
  function automatic logic [15:0] operand(input logic [1:0] r, input logic [15:0] v);
    if (FWD && exmem_wb && exmem_rd == r) return exmem_val;
    if (FWD && memwb_wb && memwb_rd == r) return memwb_val;
    return v;
  endfunction
  function automatic logic writer_pending(input logic [1:0] r);
    if (FWD) return m.valid && m.wb && m.op == LWD && m.rd == r;
    return (m.valid && m.wb && m.rd == r) || (exmem_wb && exmem_rd == r) || (memwb_wb && memwb_rd == r);
  endfunction
  function automatic logic hazard();
    return id_valid && ((id_use_rs && writer_pending(id_rs)) || (id_use_rt && writer_pending(id_rt)));
  endfunction
  function automatic logic exp_ready();
    return !stall && !hazard();
  endfunction
  function automatic instr_t decoded();
    instr_t t;
    t = '{valid: id_valid && !hazard(), use_rs: id_use_rs, use_rt: id_use_rt, use_imm: id_use_imm,
          use_pc: id_use_pc, wb: id_wb, op: id_op, rs: id_rs, rt: id_rt, rd: id_rd,
          rs_val: id_rs_val, rt_val: id_rt_val, pc: id_pc, imm: id_imm};
    return t;
  endfunction
  // model of the instruction held in the stage
  always @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      m <= '0;
      ready_q <= 1'b1;
    end else begin
      ready_q <= exp_ready();
      if (flush) m.valid <= 1'b0;
      else if (stall) begin
        if (memwb_wb && memwb_rd == m.rs) m.rs_val <= memwb_val;
        if (memwb_wb && memwb_rd == m.rt) m.rt_val <= memwb_val;
      end else m <= decoded();
    end
  // compare DUT against the model mid-cycle
  always @(negedge clk)
    if (reset_n) begin
      chk("id_ready", id_ready, exp_ready());
      chk("ex_valid", ex_valid, m.valid);
      chk("ex_wb", ex_wb, m.valid && m.wb);
      if (m.valid) begin
        chk("alu_op", alu_op, m.op);
        chk("ex_rd", ex_rd, m.rd);
        chk("alu_a", alu_a, m.use_pc ? m.pc : operand(m.rs, m.rs_val));
        chk("alu_b", alu_b, m.use_imm ? {8'h00, m.imm} : operand(m.rt, m.rt_val));
      end
    end
  task automatic idle();
    id_valid = 0; id_op = 0; id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
    id_rs_val = 0; id_rt_val = 0; id_imm = 0; id_use_imm = 0; id_pc = 0; id_use_pc = 0;
    id_wb = 0; id_rd = 0; stall = 0; flush = 0;
    exmem_wb = 0; exmem_rd = 0; exmem_val = 0; memwb_wb = 0; memwb_rd = 0; memwb_val = 0;
  endtask
  task automatic present(input logic [5:0] op, input logic [1:0] rs, input logic [1:0] rt, input logic urs,
                         input logic urt, input logic [15:0] rsv, input logic [15:0] rtv, input logic wb,
                         input logic [1:0] rd);
    id_valid = 1; id_op = op; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
    id_rs_val = rsv; id_rt_val = rtv; id_use_imm = 0; id_use_pc = 0; id_wb = wb; id_rd = rd;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    idle();
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
    #1;
    chk("rst_valid", ex_valid, 0);
    chk("rst_wb", ex_wb, 0);
    chk("rst_rd", ex_rd, 0);
    chk("rst_op", alu_op, 0);
    chk("rst_a", alu_a, 0);
    chk("rst_b", alu_b, 0);
    chk("rst_ready", id_ready, 1);
    tick();
    present(ADD, 1, 2, 1, 1, 16'h0003, 16'h0004, 1, 3);
    tick(); idle(); #1;
    chk("add_valid", ex_valid, 1);
    chk("add_a", alu_a, 16'h0003);
    chk("add_b", alu_b, 16'h0004);
    present(BPC, 0, 0, 0, 0, 0, 0, 0, 0);
    id_use_pc = 1; id_pc = 16'h0010; id_use_imm = 1; id_imm = 8'hFE;
    tick(); idle(); #1;
    chk("bpc_a", alu_a, 16'h0010);
    chk("bpc_b", alu_b, 16'h00FE);
    chk("bpc_op", alu_op, BPC);
    present(ADD, 0, 0, 0, 0, 1, 1, 1, 2);
    tick(); idle(); stall = 1; flush = 1;
    tick(); idle(); #1;
    chk("flush_valid", ex_valid, 0);
    chk("flush_wb", ex_wb, 0);
    present(ADD, 3, 0, 1, 0, 0, 0, 0, 0);
    tick();
    present(ADD, 1, 1, 1, 1, 16'h5555, 16'h1111, 0, 0);
    stall = 1; memwb_wb = 1; memwb_rd = 3; memwb_val = 16'hBEEF;
    for (int i = 0; i < 3; i++) begin
      #1 chk("stall_ready", id_ready, 0);
      tick();
    end
    stall = 0; memwb_wb = 0;
    #1;
    chk("stall_a", alu_a, 16'hBEEF);
    chk("stall_valid", ex_valid, 1);
    tick(); idle(); #1;
    chk("release_a", alu_a, 16'h5555);
    present(ADD, 0, 0, 0, 0, 0, 0, 1, 1);
    tick();
    present(ADD, 1, 2, 1, 0, 0, 0, 0, 0);
    if (FWD) begin
      #1 chk("b2b_ready", id_ready, 1);
      tick(); idle();
      exmem_wb = 1; exmem_rd = 1; exmem_val = 16'h1234;
      #1;
    end else begin
      #1 chk("b2b_ready_ex", id_ready, 0);
      tick();
      exmem_wb = 1; exmem_rd = 1; exmem_val = 16'h1234;
      #1 chk("b2b_ready_mem", id_ready, 0);
      tick();
      exmem_wb = 0; memwb_wb = 1; memwb_rd = 1; memwb_val = 16'h1234;
      #1 chk("b2b_ready_wb", id_ready, 0);
      tick();
      memwb_wb = 0; id_rs_val = 16'h1234;
      #1 chk("b2b_ready_go", id_ready, 1);
      tick(); idle(); #1;
    end
    chk("b2b_a", alu_a, 16'h1234);
    chk("b2b_valid", ex_valid, 1);
    tick();
    if (FWD) begin
      present(LWD, 0, 0, 0, 0, 0, 0, 1, 2);
      tick();
      present(ADD, 0, 2, 0, 1, 0, 0, 0, 0);
      #1 chk("lu_ready", id_ready, 0);
      tick();
      exmem_wb = 1; exmem_rd = 2;
      #1 chk("lu_bubble", ex_valid, 0);
      chk("lu_ready_go", id_ready, 1);
      tick(); idle();
      memwb_wb = 1; memwb_rd = 2; memwb_val = 16'h7777;
      #1 chk("lu_valid", ex_valid, 1);
      chk("lu_b", alu_b, 16'h7777);
      tick(); idle();
    end
    present(ADD, 0, 0, 0, 0, 9, 9, 1, 1);
    tick(); idle(); stall = 1;
    #2 reset_n = 0;
    #1 chk("areset_valid", ex_valid, 0);
    chk("areset_wb", ex_wb, 0);
    @(posedge clk);
    #1 reset_n = 1; stall = 0;
    tick();
    for (int i = 0; i < 3000; i++) begin
      if (ready_q) begin
        id_valid = $urandom_range(0, 3) != 0;
        id_op = $urandom_range(0, 3) == 0 ? LWD : 6'($urandom);
        id_rs = 2'($urandom); id_rt = 2'($urandom); id_rd = 2'($urandom);
        id_use_rs = 1'($urandom); id_use_rt = 1'($urandom);
        id_use_imm = $urandom_range(0, 3) == 0; id_use_pc = $urandom_range(0, 3) == 0;
        id_rs_val = 16'($urandom); id_rt_val = 16'($urandom); id_pc = 16'($urandom);
        id_imm = 8'($urandom); id_wb = 1'($urandom);
      end
      stall = $urandom_range(0, 4) == 0;
      flush = $urandom_range(0, 9) == 0;
      exmem_wb = 1'($urandom); exmem_rd = 2'($urandom); exmem_val = 16'($urandom);
      memwb_wb = 1'($urandom); memwb_rd = 2'($urandom); memwb_val = 16'($urandom);
      tick();
    end
    idle();
    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
